// File: rtl/dmem_arbiter_if.sv
// Requester/memory bus for dmem_arbiter.
// slave  : arbiter side (consumes requests and memory read data, drives grants and memory controls).
// master : requesters plus data memory (the arbiter's environment).
// Optional error pulses exist only when DMEM_ARB_ERR_EN is defined.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_rvalid;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_rvalid;

`ifdef DMEM_ARB_ERR_EN
    logic              p0_err;
    logic              p1_err;
`endif

    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rdata, p0_rvalid,
        output p1_gnt, p1_rdata, p1_rvalid,
        output mem_write, mem_read, mem_addr, mem_wdata
`ifdef DMEM_ARB_ERR_EN
        , output p0_err, p1_err
`endif
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rdata, p0_rvalid,
        input  p1_gnt, p1_rdata, p1_rvalid,
        input  mem_write, mem_read, mem_addr, mem_wdata
`ifdef DMEM_ARB_ERR_EN
        , input p0_err, p1_err
`endif
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Port 0 = core load/store, port 1 = DMA/debug loader. Grants are combinational,
// round-robin on ties, and an owner keeps the memory for at most MAX_BURST
// consecutive cycles while the other port waits. Read data returns one cycle after grant.
// Optional feature: define DMEM_ARB_ERR_EN to range-check addresses against DEPTH
// (out-of-range accesses are granted but suppressed, and flagged on pN_err).
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
`ifdef DMEM_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int             CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  MAXB = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      last_q, last_d;

    logic [1:0]                req, we, gnt, oob;
    logic [1:0][ADDR_W-1:0]    addr;
    logic [1:0][DATA_W-1:0]    wdata;
    logic                      sel, any;

    logic [1:0][DATA_W-1:0]    rdata_q;
    logic [1:0]                rvalid_q;

    assign req   = {bus.p1_req,   bus.p0_req};
    assign we    = {bus.p1_we,    bus.p0_we};
    assign addr  = {bus.p1_addr,  bus.p0_addr};
    assign wdata = {bus.p1_wdata, bus.p0_wdata};

    // Range check collapses to constant 0 when the feature is compiled out.
    assign oob[0] = ERR_EN && (addr[0] >= ADDR_W'(DEPTH));
    assign oob[1] = ERR_EN && (addr[1] >= ADDR_W'(DEPTH));

    // FSM state register: owner of last grant, burst length, tie-break history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state: follow whichever port was granted this cycle.
    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = last_q;
        if (gnt[0]) begin
            state_d = OWN0;
            last_d  = 1'b0;
            cnt_d   = (state_q != OWN0) ? CW'(1) : (cnt_q == MAXB) ? cnt_q : cnt_q + CW'(1);
        end else if (gnt[1]) begin
            state_d = OWN1;
            last_d  = 1'b1;
            cnt_d   = (state_q != OWN1) ? CW'(1) : (cnt_q == MAXB) ? cnt_q : cnt_q + CW'(1);
        end
    end

    // FSM outputs: grant decision; forced low while reset is asserted.
    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            case (state_q)
                IDLE:    gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
                OWN0:    if (req[0] && (!req[1] || cnt_q < MAXB)) gnt = 2'b01;
                         else if (req[1])                         gnt = 2'b10;
                OWN1:    if (req[1] && (!req[0] || cnt_q < MAXB)) gnt = 2'b10;
                         else if (req[0])                         gnt = 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Memory-side mux from the granted port; idle bus is all zeros.
    always_comb begin
        any           = |gnt;
        sel           = gnt[1];
        bus.mem_write = any &  we[sel] & ~oob[sel];
        bus.mem_read  = any & ~we[sel] & ~oob[sel];
        bus.mem_addr  = any ? addr[sel]  : '0;
        bus.mem_wdata = any ? wdata[sel] : '0;
    end

    // Read return: capture memory data at the grant edge, pulse rvalid next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_q[i] <= gnt[i] & ~we[i];
                if (gnt[i] && !we[i])
                    rdata_q[i] <= oob[i] ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];
    assign bus.p0_rdata  = rdata_q[0];
    assign bus.p1_rdata  = rdata_q[1];
    assign bus.p0_rvalid = rvalid_q[0];
    assign bus.p1_rvalid = rvalid_q[1];

`ifdef DMEM_ARB_ERR_EN
    logic [1:0] err_q;

    // Error pulse lands in the response cycle for both reads and writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 2'b00;
        else        err_q <= gnt & oob;
    end

    assign bus.p0_err = err_q[0];
    assign bus.p1_err = err_q[1];
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus hand sequences for
// async reset mid-read, reset of the tie-break, and (with DMEM_ARB_ERR_EN) range errors.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Memory model: combinational read, write commits at the rising edge.
    logic [31:0] mem [0:63];
    bit          seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            mem[0]  <= 32'hAAAA5555;
            mem[1]  <= 32'h00000011;
            mem[2]  <= 32'h00000022;
            mem[63] <= 32'hCAFEF00D;
            seeded  <= 1'b1;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

    typedef struct {
        logic r0, w0; logic [31:0] a0, d0;
        logic r1, w1; logic [31:0] a1, d1;
        logic [1:0] g; logic mw, mr; logic [31:0] ma, md;
        logic [1:0] rv; logic [31:0] rd0, rd1;
    } vec_t;

    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] DB = 32'hDEADBEEF;

    vec_t v [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                         input logic r1, w1, input logic [31:0] a1, d1);
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        // rows: p0 in, p1 in, expected gnt/mem_write/mem_read/mem_addr/mem_wdata, rvalid, rdata0, rdata1
        v[0]  = '{1'b0,1'b0,Z,Z,           1'b0,1'b0,Z,Z,           2'b00,1'b0,1'b0,Z,Z,                    2'b00,Z,Z};
        v[1]  = '{1'b1,1'b0,32'd1,Z,       1'b1,1'b0,32'd2,Z,       2'b01,1'b0,1'b1,32'd1,Z,                2'b00,Z,Z};
        v[2]  = '{1'b0,1'b0,Z,Z,           1'b1,1'b0,32'd2,Z,       2'b10,1'b0,1'b1,32'd2,Z,                2'b01,32'h11,Z};
        v[3]  = '{1'b0,1'b0,Z,Z,           1'b0,1'b0,Z,Z,           2'b00,1'b0,1'b0,Z,Z,                    2'b10,32'h11,32'h22};
        v[4]  = '{1'b1,1'b1,32'd5,DB,      1'b0,1'b0,Z,Z,           2'b01,1'b1,1'b0,32'd5,DB,               2'b00,32'h11,32'h22};
        v[5]  = '{1'b1,1'b0,32'd5,Z,       1'b0,1'b0,Z,Z,           2'b01,1'b0,1'b1,32'd5,Z,                2'b00,32'h11,32'h22};
        v[6]  = '{1'b0,1'b0,Z,Z,           1'b0,1'b0,Z,Z,           2'b00,1'b0,1'b0,Z,Z,                    2'b01,DB,32'h22};
        v[7]  = '{1'b0,1'b0,Z,Z,           1'b1,1'b1,32'd10,32'hA5A5A5A5, 2'b10,1'b1,1'b0,32'd10,32'hA5A5A5A5, 2'b00,DB,32'h22};
        v[8]  = '{1'b0,1'b0,Z,Z,           1'b0,1'b0,Z,Z,           2'b00,1'b0,1'b0,Z,Z,                    2'b00,DB,32'h22};
        // both write continuously: grants 0,0,0,0,1,1,1,1,0
        for (int i = 9; i <= 17; i++) begin
            logic p1win;
            p1win = (i >= 13 && i <= 16);
            v[i] = '{1'b1,1'b1,32'd20,32'h100, 1'b1,1'b1,32'd21,32'h200,
                     p1win ? 2'b10 : 2'b01, 1'b1, 1'b0, p1win ? 32'd21 : 32'd20,
                     p1win ? 32'h200 : 32'h100, 2'b00, DB, 32'h22};
        end
        v[18] = '{1'b0,1'b0,Z,Z,           1'b0,1'b0,Z,Z,           2'b00,1'b0,1'b0,Z,Z,                    2'b00,DB,32'h22};
        v[19] = '{1'b1,1'b0,32'd20,Z,      1'b0,1'b0,Z,Z,           2'b01,1'b0,1'b1,32'd20,Z,               2'b00,DB,32'h22};
        v[20] = '{1'b0,1'b0,Z,Z,           1'b1,1'b0,32'd21,Z,      2'b10,1'b0,1'b1,32'd21,Z,               2'b01,32'h100,32'h22};
        v[21] = '{1'b0,1'b0,Z,Z,           1'b0,1'b0,Z,Z,           2'b00,1'b0,1'b0,Z,Z,                    2'b10,32'h100,32'h200};

        // reset state, with a request present while held in reset
        reset = 1'b0;
        drive(1'b1,1'b0,32'd1,Z, 1'b0,1'b0,Z,Z);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",    {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
        chk("rst_mem_rd", {31'd0, bus.mem_read}, 32'd0);
        chk("rst_maddr",  bus.mem_addr, 32'd0);
        chk("rst_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
        chk("rst_rdata0", bus.p0_rdata, 32'd0);
        cyc();
        drive(1'b0,1'b0,Z,Z, 1'b0,1'b0,Z,Z);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            cyc();
            drive(v[i].r0, v[i].w0, v[i].a0, v[i].d0, v[i].r1, v[i].w1, v[i].a1, v[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i),    {30'd0, bus.p1_gnt, bus.p0_gnt}, {30'd0, v[i].g});
            chk($sformatf("v%0d_onehot", i), {31'd0, bus.p1_gnt & bus.p0_gnt}, 32'd0);
            chk($sformatf("v%0d_mw", i),     {31'd0, bus.mem_write}, {31'd0, v[i].mw});
            chk($sformatf("v%0d_mr", i),     {31'd0, bus.mem_read},  {31'd0, v[i].mr});
            chk($sformatf("v%0d_maddr", i),  bus.mem_addr,  v[i].ma);
            chk($sformatf("v%0d_mwdata", i), bus.mem_wdata, v[i].md);
            chk($sformatf("v%0d_rvalid", i), {30'd0, bus.p1_rvalid, bus.p0_rvalid}, {30'd0, v[i].rv});
            chk($sformatf("v%0d_rdata0", i), bus.p0_rdata, v[i].rd0);
            chk($sformatf("v%0d_rdata1", i), bus.p1_rdata, v[i].rd1);
        end

        // async reset in the middle of back-to-back reads by p0
        cyc();
        drive(1'b1,1'b0,32'd1,Z, 1'b0,1'b0,Z,Z);
        @(negedge clk);
        chk("mid_gnt_a", {31'd0, bus.p0_gnt}, 32'd1);
        cyc();
        drive(1'b1,1'b0,32'd2,Z, 1'b0,1'b0,Z,Z);
        @(negedge clk);
        chk("mid_rvalid_a", {31'd0, bus.p0_rvalid}, 32'd1);
        chk("mid_rdata_a",  bus.p0_rdata, 32'h11);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_gnt",    {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
        chk("mid_rst_mr",     {31'd0, bus.mem_read}, 32'd0);
        chk("mid_rst_maddr",  bus.mem_addr, 32'd0);
        chk("mid_rst_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
        chk("mid_rst_rdata0", bus.p0_rdata, 32'd0);
        chk("mid_rst_rdata1", bus.p1_rdata, 32'd0);
        drive(1'b0,1'b0,Z,Z, 1'b0,1'b0,Z,Z);
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_rvalid%0d", k), {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
        end
        // tie-break history must be back to "port 0 first"
        cyc();
        drive(1'b1,1'b0,32'd1,Z, 1'b1,1'b0,32'd2,Z);
        @(negedge clk);
        chk("post_rst_tie", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd1);
        cyc();
        drive(1'b0,1'b0,Z,Z, 1'b1,1'b0,32'd2,Z);
        @(negedge clk);
        chk("post_rst_p1", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd2);
        cyc();
        drive(1'b0,1'b0,Z,Z, 1'b0,1'b0,Z,Z);

`ifdef DMEM_ARB_ERR_EN
        // out-of-range write by p1: granted, suppressed, error one cycle later
        cyc();
        drive(1'b0,1'b0,Z,Z, 1'b1,1'b1,32'd64,32'h12345678);
        @(negedge clk);
        chk("err_w_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd2);
        chk("err_w_mw",  {31'd0, bus.mem_write}, 32'd0);
        chk("err_w_now", {30'd0, bus.p1_err, bus.p0_err}, 32'd0);
        cyc();
        drive(1'b0,1'b0,Z,Z, 1'b0,1'b0,Z,Z);
        @(negedge clk);
        chk("err_w_pulse", {30'd0, bus.p1_err, bus.p0_err}, 32'd2);
        chk("err_w_mem63", mem[63], 32'hCAFEF00D);
        chk("err_w_mem0",  mem[0],  32'hAAAA5555);
        cyc();
        @(negedge clk);
        chk("err_w_done", {30'd0, bus.p1_err, bus.p0_err}, 32'd0);
        // out-of-range read by p0: zero data with rvalid and error
        cyc();
        drive(1'b1,1'b0,32'd100,Z, 1'b0,1'b0,Z,Z);
        @(negedge clk);
        chk("err_r_mr", {31'd0, bus.mem_read}, 32'd0);
        cyc();
        drive(1'b0,1'b0,Z,Z, 1'b0,1'b0,Z,Z);
        @(negedge clk);
        chk("err_r_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd1);
        chk("err_r_rdata",  bus.p0_rdata, 32'd0);
        chk("err_r_err",    {30'd0, bus.p1_err, bus.p0_err}, 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
